multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock, all state updates on the rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on the rising clk edge.
REQ-003 The block SHALL have port op, input, 6 bits: opcode from the instruction register, valid from DECODE onward.
REQ-004 The block SHALL have port mem_ready, input, 1 bit: memory handshake, high when the current read/write completes this cycle.
REQ-005 The block SHALL have outputs PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, each 1 bit: datapath enables/selects.
REQ-006 The block SHALL have outputs PCSource, ALUSrcB and ALUop, each 2 bits: datapath multiplexer selects and ALU class (00 add, 01 sub, 10 funct, 11 and).
REQ-007 The block SHALL have outputs state, 4 bits (current state code), and illegal_op, 1 bit (sticky unsupported-opcode flag).

Function
REQ-008 The block SHALL be a Moore FSM: all outputs are decoded from state only, except IRWrite/PCWrite in FETCH, which are state AND mem_ready.
REQ-009 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11; codes 12-15 SHALL go to FETCH next cycle with all outputs 0.
REQ-010 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00; IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0, go to DECODE when 1.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target precompute); next state by op: 000000->EXEC, 000010->JUMP, 000100/000101->BRANCH, 001000/001100->IEXEC, 100011/101011->MEMADR, any other->FETCH with illegal_op set to 1.
REQ-012 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00; op=100011->MEMRD, op=101011->MEMWR.
REQ-013 MEMRD: MemRead=1, IorD=1; hold while mem_ready=0; ->MEMWB when mem_ready=1.
REQ-014 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH.
REQ-015 MEMWR: MemWrite=1, IorD=1; hold while mem_ready=0; ->FETCH when mem_ready=1; MemWrite SHALL remain high for every held cycle.
REQ-016 EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10; ->RWB. RWB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01, PCWriteCondEq=1 if op=000100, PCWriteCondNe=1 if op=000101; ->FETCH.
REQ-018 JUMP: PCWrite=1, PCSource=10; ->FETCH.
REQ-019 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUop=00 for addi, 11 for andi (zero-extension selected by datapath on ALUop=11); ->IWB. IWB: RegWrite=1, RegDst=0, MemtoReg=0; ->FETCH.
REQ-020 Every output not listed for a state SHALL be 0 in that state.
REQ-021 Cycle counts with mem_ready tied high SHALL be: lw 5, sw 4, R-type 4, addi/andi 4, beq/bne 3, j 3; each low mem_ready cycle in FETCH/MEMRD/MEMWR SHALL add exactly one cycle.
REQ-022 MemRead and MemWrite SHALL never be high in the same cycle; RegWrite and PCWrite SHALL never be high in MEMRD/MEMWR.
REQ-023 illegal_op SHALL stay 1 until reset; the illegal instruction SHALL cause no RegWrite, MemWrite or PC change beyond the FETCH increment.

Reset
REQ-024 On a clk edge with reset=1, state SHALL become FETCH and illegal_op SHALL become 0, regardless of current state or mem_ready.
REQ-025 While reset=1, all enables (PCWrite, PCWriteCond*, MemWrite, RegWrite, IRWrite) SHALL be 0 in that cycle and the next cycle's FETCH begins only after reset deasserts.
REQ-026 Reset asserted mid-instruction (e.g. in MEMWR with mem_ready=0) SHALL abort it; no deferred write SHALL occur after reset.

Verification
REQ-027 mem_ready=1, op=100011: states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; total 5 cycles.
REQ-028 mem_ready=1, op=000101: states 0,1,8,0; PCWriteCondNe=1, PCWriteCondEq=0, ALUop=01 in state 8.
REQ-029 op=101011, mem_ready low for 3 cycles in MEMWR: state 5 held 4 cycles with MemWrite=1 throughout, then FETCH; total 7 cycles.
REQ-030 op=001100: state 10 with ALUop=11, ALUSrcB=10, then state 11 with RegWrite=1, RegDst=0.
REQ-031 op=111111 in DECODE: next state 0, illegal_op=1 and held through a following valid R-type (0,1,6,7,0); reset clears it to 0.
REQ-032 reset=1 asserted in state 3 with mem_ready=0: next state 0, MemRead=1 only after reset deasserts, no RegWrite pulse observed.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath: fetch, decode and
// per-class execution sequences with a memory-ready handshake and a sticky illegal-opcode flag.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCondEq,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] dec_s;

  // State and sticky-flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:        state_d = S_EXEC;
          OP_J:            state_d = S_JUMP;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset forces an unused code so every output decodes to zero in that cycle
  assign dec_s = reset ? 4'd15 : state_q;

  // Output decode from the current state
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCondEq = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    IRWrite       = 1'b0;
    ALUSrcA       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    PCSource      = 2'b00;
    ALUSrcB       = 2'b00;
    ALUop         = 2'b00;
    case (dec_s)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUop         = 2'b01;
        PCSource      = 2'b01;
        PCWriteCondEq = (op == OP_BEQ);
        PCWriteCondNe = (op == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = (op == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_IWB:   RegWrite = 1'b1;
      default: PCWrite = 1'b0;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: each instruction expands into a queue of expected per-cycle
// states/outputs built from the instruction class and the chosen memory wait counts.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUop;
  logic [3:0] state;
  logic       illegal_op;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCondEq(PCWriteCondEq), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam bit O = 1'b0;
  localparam bit I = 1'b1;
  localparam logic [5:0] RT = 6'b000000, JJ = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, LW = 6'b100011, SW = 6'b101011;

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic [5:0]  op;
    logic [16:0] vec;
    logic        ill;
  } ent_t;

  ent_t q[$];
  logic ill_model;
  int   total = 0;
  int   bad   = 0;
  logic [16:0] obs;

  assign obs = {PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUop};

  function automatic logic [16:0] fv(input bit pcw, ceq, cne, iord, mrd, mwr, m2r, irw,
                                     asa, rw, rd, input bit [1:0] pcs, asb, aop);
    return {pcw, ceq, cne, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop};
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == RT) || (o == JJ) || (o == BEQ) || (o == BNE) ||
           (o == ADDI) || (o == ANDI) || (o == LW) || (o == SW);
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] o, input logic [16:0] v);
    ent_t e;
    e.st = st; e.mr = mr; e.op = o; e.vec = v; e.ill = ill_model;
    q.push_back(e);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction.
  task automatic build(input logic [5:0] o, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, 6'($urandom), fv(O,O,O,O,I,O,O,O,O,O,O,2'b00,2'b01,2'b00));
    push(4'd0, 1'b1, 6'($urandom), fv(I,O,O,O,I,O,O,I,O,O,O,2'b00,2'b01,2'b00));
    push(4'd1, rbit(), o, fv(O,O,O,O,O,O,O,O,O,O,O,2'b00,2'b11,2'b00));
    if (o == LW) begin
      push(4'd2, rbit(), o, fv(O,O,O,O,O,O,O,O,I,O,O,2'b00,2'b10,2'b00));
      for (int i = 0; i < mw; i++) push(4'd3, 1'b0, o, fv(O,O,O,I,I,O,O,O,O,O,O,2'b00,2'b00,2'b00));
      push(4'd3, 1'b1, o, fv(O,O,O,I,I,O,O,O,O,O,O,2'b00,2'b00,2'b00));
      push(4'd4, rbit(), o, fv(O,O,O,O,O,O,I,O,O,I,O,2'b00,2'b00,2'b00));
    end else if (o == SW) begin
      push(4'd2, rbit(), o, fv(O,O,O,O,O,O,O,O,I,O,O,2'b00,2'b10,2'b00));
      for (int i = 0; i < mw; i++) push(4'd5, 1'b0, o, fv(O,O,O,I,O,I,O,O,O,O,O,2'b00,2'b00,2'b00));
      push(4'd5, 1'b1, o, fv(O,O,O,I,O,I,O,O,O,O,O,2'b00,2'b00,2'b00));
    end else if (o == RT) begin
      push(4'd6, rbit(), o, fv(O,O,O,O,O,O,O,O,I,O,O,2'b00,2'b00,2'b10));
      push(4'd7, rbit(), o, fv(O,O,O,O,O,O,O,O,O,I,I,2'b00,2'b00,2'b00));
    end else if (o == BEQ || o == BNE) begin
      push(4'd8, rbit(), o, fv(O,(o == BEQ),(o == BNE),O,O,O,O,O,I,O,O,2'b01,2'b00,2'b01));
    end else if (o == JJ) begin
      push(4'd9, rbit(), o, fv(I,O,O,O,O,O,O,O,O,O,O,2'b10,2'b00,2'b00));
    end else if (o == ADDI || o == ANDI) begin
      push(4'd10, rbit(), o, fv(O,O,O,O,O,O,O,O,I,O,O,2'b00,2'b10,(o == ANDI) ? 2'b11 : 2'b00));
      push(4'd11, rbit(), o, fv(O,O,O,O,O,O,O,O,O,I,O,2'b00,2'b00,2'b00));
    end else begin
      ill_model = 1'b1;
    end
  endtask

  task automatic step(input ent_t e);
    @(negedge clk);
    reset = 1'b0; op = e.op; mem_ready = e.mr;
    #1;
    total++;
    assert (state === e.st) else begin bad++; $error("FAIL state obs=%0d exp=%0d", state, e.st); end
    total++;
    assert (obs === e.vec) else begin bad++; $error("FAIL outputs st=%0d obs=%h exp=%h", e.st, obs, e.vec); end
    total++;
    assert (illegal_op === e.ill) else begin bad++; $error("FAIL illegal_op obs=%b exp=%b", illegal_op, e.ill); end
    total++;
    assert (!(MemRead && MemWrite)) else begin bad++; $error("FAIL rd_wr_excl obs=%b%b exp=not both", MemRead, MemWrite); end
  endtask

  task automatic run_n(input int n);
    ent_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      step(e);
    end
  endtask

  task automatic rst_cycle(input bit chk_ill);
    @(negedge clk);
    reset = 1'b1; op = 6'($urandom); mem_ready = rbit();
    #1;
    total++;
    assert (obs === 17'd0) else begin bad++; $error("FAIL reset_outputs obs=%h exp=%h", obs, 17'd0); end
    if (chk_ill) begin
      total++;
      assert (illegal_op === ill_model) else begin bad++; $error("FAIL reset_ill obs=%b exp=%b", illegal_op, ill_model); end
    end
    q.delete();
    ill_model = 1'b0;
  endtask

  initial begin
    logic [5:0] legal [8];
    logic [5:0] o;
    legal = '{RT, JJ, BEQ, BNE, ADDI, ANDI, LW, SW};
    reset = 1'b1; op = 6'd0; mem_ready = 1'b0; ill_model = 1'b0;
    rst_cycle(1'b0);
    rst_cycle(1'b1);

    build(LW, 0, 0);   run_n(100);
    build(BNE, 0, 0);  run_n(100);
    build(SW, 0, 3);   run_n(100);
    build(ANDI, 0, 0); run_n(100);
    build(6'b111111, 0, 0); run_n(100);
    build(RT, 1, 0);   run_n(100);
    rst_cycle(1'b1);
    build(BEQ, 0, 0);  run_n(100);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        o = legal[$urandom_range(0, 7)];
      end else begin
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
      end
      build(o, $urandom_range(0, 2), $urandom_range(0, 3));
      run_n(100);
    end

    // abort a load while the read is stalled, then a store while the write is stalled
    build(LW, 0, 3); run_n(4);
    rst_cycle(1'b1);
    build(RT, 0, 0); run_n(100);
    build(SW, 1, 3); run_n(5);
    rst_cycle(1'b1);
    build(JJ, 0, 0); run_n(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
